array_14_ctrl: RTL and testbench

- Front-end controller for the 1024 x 528-bit single-port array macro (16 write-mask lanes of 33 bits, 1-cycle read latency).
- Zero-fills the array after reset, then arbitrates one write requester and one read requester onto the single RW port.
- Captures read data into a 2-entry response buffer with valid/ready backpressure, so the data is held stable regardless of macro output behaviour after the read cycle.

---
 rtl/array_14_ctrl.sv | 149 ++++++++++++++
 tb/tb_array_14_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/array_14_ctrl.sv
// array_14_ctrl: front end for the 1024 x 528 single-port array macro.
// Zero-fills the array after reset, then arbitrates one writer and one
// reader onto the RW port. Read data is captured into a 2-entry response
// buffer so it stays stable whatever the macro output does afterwards.
module array_14_ctrl #(
   parameter int ADDR_W     = 10,
   parameter int DEPTH      = 1024,
   parameter int DATA_W     = 528,
   parameter int MASK_W     = 16,
   parameter int STARVE_MAX = 4,
   parameter bit INIT_EN    = 1'b1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [MASK_W-1:0] wr_mask,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_valid,
   output logic              rd_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              init_done,
   output logic [ADDR_W-1:0] sram_addr,
   output logic              sram_en,
   output logic              sram_wmode,
   output logic [MASK_W-1:0] sram_wmask,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata
);

   localparam int                SW         = $clog2(STARVE_MAX + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
   localparam logic [SW-1:0]     STARVE_LIM = SW'(STARVE_MAX);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] init_cnt;
   logic              rd_inflight;
   logic [SW-1:0]     starve;
   logic [1:0]        count;
   logic              wptr, rptr;
   logic [DATA_W-1:0] rbuf [2];
   logic              push, pop, rd_elig, rd_gnt, wr_gnt;
   logic [2:0]        occ;

   // Buffer head and occupancy as seen after this cycle's pop; a read may
   // only be granted if its response is guaranteed a slot.
   assign resp_valid = (count != 2'd0);
   assign resp_data  = rbuf[rptr];
   assign pop        = resp_valid && resp_ready;
   assign push       = rd_inflight;
   assign occ        = 3'(count) + 3'(rd_inflight) - 3'(pop);

   // Next state, arbitration and macro drive; everything idles at zero.
   always_comb begin
      state_nxt  = state;
      rd_elig    = 1'b0;
      rd_gnt     = 1'b0;
      wr_gnt     = 1'b0;
      wr_ready   = 1'b0;
      rd_ready   = 1'b0;
      sram_en    = 1'b0;
      sram_wmode = 1'b0;
      sram_addr  = '0;
      sram_wmask = '0;
      sram_wdata = '0;
      if (state == ST_INIT) begin
         sram_en    = 1'b1;
         sram_wmode = 1'b1;
         sram_wmask = '1;
         sram_addr  = init_cnt;
         if (init_cnt == LAST_ADDR) state_nxt = ST_RUN;
      end else begin
         rd_elig  = rd_valid && (occ < 3'd2);
         // write has priority unless the reader has lost STARVE_MAX times
         rd_gnt   = rd_elig && (!wr_valid || (starve == STARVE_LIM));
         wr_gnt   = wr_valid && !rd_gnt;
         wr_ready = wr_gnt;
         rd_ready = rd_gnt;
         if (wr_gnt) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = wr_addr;
            sram_wmask = wr_mask;
            sram_wdata = wr_data;
         end else if (rd_gnt) begin
            sram_en    = 1'b1;
            sram_addr  = rd_addr;
         end
      end
   end

   // State register.
   always_ff @(posedge clock) begin
      if (!reset_n) state <= INIT_EN ? ST_INIT : ST_RUN;
      else          state <= state_nxt;
   end

   // Fill address counter and sticky completion flag.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         init_cnt  <= '0;
         init_done <= !INIT_EN;
      end else if (state == ST_INIT) begin
         init_cnt <= init_cnt + 1'b1;
         if (init_cnt == LAST_ADDR) init_done <= 1'b1;
      end
   end

   // Read-in-flight flag and saturating starvation counter.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         rd_inflight <= 1'b0;
         starve      <= '0;
      end else begin
         rd_inflight <= rd_gnt;
         if (rd_gnt)                              starve <= '0;
         else if (rd_elig && starve != STARVE_LIM) starve <= starve + 1'b1;
      end
   end

   // Response buffer pointers and occupancy; reset drops buffered data.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         count <= 2'd0;
         wptr  <= 1'b0;
         rptr  <= 1'b0;
      end else begin
         if (push) wptr <= ~wptr;
         if (pop)  rptr <= ~rptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Capture macro read data in the cycle after the grant.
   always_ff @(posedge clock) begin
      if (push) rbuf[wptr] <= sram_rdata;
   end

endmodule

// File: tb/tb_array_14_ctrl.sv
// Directed bench for array_14_ctrl with a behavioural model of the macro.
module tb_array_14_ctrl;

   logic         clock = 1'b0;
   logic         reset_n;
   logic         wr_valid, wr_ready, rd_valid, rd_ready;
   logic [9:0]   wr_addr, rd_addr, sram_addr;
   logic [15:0]  wr_mask, sram_wmask;
   logic [527:0] wr_data, resp_data, sram_wdata, sram_rdata;
   logic         resp_valid, resp_ready, init_done, sram_en, sram_wmode;

   int vecs = 0;
   int errs = 0;

   always #5 clock = ~clock;

   array_14_ctrl #(
      .ADDR_W(10), .DEPTH(1024), .DATA_W(528), .MASK_W(16),
      .STARVE_MAX(4), .INIT_EN(1'b1)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
      .wr_mask(wr_mask), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .init_done(init_done),
      .sram_addr(sram_addr), .sram_en(sram_en), .sram_wmode(sram_wmode),
      .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   // Macro model: masked 33-bit lanes, 1-cycle read; output scrambles on
   // every non-read cycle so late capture is visible.
   logic [527:0] mem [1024];
   logic [527:0] wtmp;
   logic [527:0] rdq;
   assign sram_rdata = rdq;

   always_comb begin
      wtmp = mem[sram_addr];
      for (int l = 0; l < 16; l++)
         if (sram_wmask[l]) wtmp[l*33 +: 33] = sram_wdata[l*33 +: 33];
   end

   always @(posedge clock) begin
      if (sram_en && sram_wmode) mem[sram_addr] <= wtmp;
      if (sram_en && !sram_wmode) rdq <= mem[sram_addr];
      else                        rdq <= ~rdq;
   end

   function automatic logic [527:0] pat(input logic [9:0] a);
      logic [32:0] lane;
      lane = {23'h5A5A5A ^ {13'd0, a}, a};
      return {16{lane}};
   endfunction

   // Stimulus only: single write, assumes RUN, no read pending, at negedge.
   task automatic do_write(input logic [9:0] a, input logic [15:0] m, input logic [527:0] d);
      wr_valid = 1'b1; wr_addr = a; wr_mask = m; wr_data = d;
      @(posedge clock); @(negedge clock);
      wr_valid = 1'b0;
   endtask

   // Stimulus only: single read, samples head two edges after grant, pops it.
   task automatic read_one(input logic [9:0] a, output logic v, output logic [527:0] d);
      rd_valid = 1'b1; rd_addr = a;
      @(posedge clock); @(negedge clock);
      rd_valid = 1'b0;
      @(posedge clock); #1;
      v = resp_valid; d = resp_data;
      @(negedge clock); resp_ready = 1'b1;
      @(posedge clock); @(negedge clock); resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      int n;
      logic v;
      logic [527:0] d;
      reset_n = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0; resp_ready = 1'b0;
      wr_addr = '0; wr_mask = '0; wr_data = '0; rd_addr = '0;
      repeat (3) @(negedge clock);
      wr_valid = 1'b1; rd_valid = 1'b1; #1;
      vecs++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
      vecs++; if (init_done !== 1'b0) begin errs++; $display("FAIL reset_init_done got %b want 0", init_done); end
      vecs++; if ({wr_ready, rd_ready} !== 2'b00) begin errs++; $display("FAIL init_no_grant got %b want 00", {wr_ready, rd_ready}); end
      vecs++; if ({sram_en, sram_wmode, sram_wmask, sram_addr} !== {2'b11, 16'hFFFF, 10'h000})
         begin errs++; $display("FAIL init_drive got en=%b wm=%b mask=%h addr=%h want 1 1 ffff 000", sram_en, sram_wmode, sram_wmask, sram_addr); end
      wr_valid = 1'b0; rd_valid = 1'b0;
      reset_n = 1'b1;
      n = 0;
      while (n < 2000) begin
         @(posedge clock); #1; n++;
         if (n == 5) begin
            vecs++; if (sram_addr !== 10'd5) begin errs++; $display("FAIL init_counter got %h want 005", sram_addr); end
         end
         if (init_done) break;
      end
      vecs++; if (n !== 1024) begin errs++; $display("FAIL init_latency got %0d want 1024", n); end
      @(negedge clock); #1;
      vecs++; if ({sram_en, sram_addr, sram_wdata} !== '0) begin errs++; $display("FAIL idle_zero got en=%b addr=%h want all zero", sram_en, sram_addr); end
      read_one(10'h3FF, v, d);
      vecs++; if (v !== 1'b1 || d !== '0) begin errs++; $display("FAIL fill_read_3ff got v=%b d=%h want 1 0", v, d); end
   endtask

   task automatic test_write_read();
      logic [527:0] a;
      a = pat(10'h005);
      wr_valid = 1'b1; wr_addr = 10'h005; wr_mask = 16'hFFFF; wr_data = a; #1;
      vecs++; if ({wr_ready, sram_en, sram_wmode, sram_addr} !== {3'b111, 10'h005})
         begin errs++; $display("FAIL wr_grant got rdy=%b en=%b wm=%b addr=%h want 1 1 1 005", wr_ready, sram_en, sram_wmode, sram_addr); end
      vecs++; if (sram_wdata !== a) begin errs++; $display("FAIL wr_wdata got %h want %h", sram_wdata, a); end
      @(posedge clock); @(negedge clock);
      wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 10'h005; #1;
      vecs++; if ({rd_ready, wr_ready, sram_en, sram_wmode} !== 4'b1010)
         begin errs++; $display("FAIL rd_grant got rr=%b wr=%b en=%b wm=%b want 1 0 1 0", rd_ready, wr_ready, sram_en, sram_wmode); end
      @(posedge clock); #1;
      vecs++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL rd_lat_edge1 got %b want 0", resp_valid); end
      @(negedge clock); rd_valid = 1'b0;
      @(posedge clock); #1;
      vecs++; if (resp_valid !== 1'b1 || resp_data !== a) begin errs++; $display("FAIL rd_lat_edge2 got v=%b d=%h want 1 %h", resp_valid, resp_data, a); end
      repeat (3) @(negedge clock);
      vecs++; if (resp_data !== a) begin errs++; $display("FAIL resp_hold got %h want %h", resp_data, a); end
      resp_ready = 1'b1;
      @(posedge clock); #1;
      vecs++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL resp_pop got %b want 0", resp_valid); end
      @(negedge clock); resp_ready = 1'b0;
   endtask

   task automatic test_mask();
      logic v;
      logic [527:0] d, e;
      e = pat(10'h005);
      e[32:0] = '1;
      do_write(10'h005, 16'h0001, '1);
      read_one(10'h005, v, d);
      vecs++; if (v !== 1'b1 || d !== e) begin errs++; $display("FAIL mask_lane0 got %h want %h", d, e); end
      wr_valid = 1'b1; wr_addr = 10'h005; wr_mask = 16'h0000; wr_data = '0; #1;
      vecs++; if ({wr_ready, sram_en} !== 2'b11) begin errs++; $display("FAIL mask_zero_accept got rdy=%b en=%b want 1 1", wr_ready, sram_en); end
      @(posedge clock); @(negedge clock); wr_valid = 1'b0;
      read_one(10'h005, v, d);
      vecs++; if (v !== 1'b1 || d !== e) begin errs++; $display("FAIL mask_zero_nochange got %h want %h", d, e); end
   endtask

   task automatic test_arbitration();
      int ri, wi, oi;
      logic exp_r;
      for (int i = 0; i < 4; i++) do_write(10'(10'h020 + i), 16'hFFFF, pat(10'(10'h020 + i)));
      ri = 0; wi = 0; oi = 0;
      resp_ready = 1'b1; wr_valid = 1'b1; rd_valid = 1'b1; wr_mask = 16'hFFFF;
      for (int c = 0; c < 15; c++) begin
         rd_addr = 10'(10'h020 + ri); wr_addr = 10'(10'h100 + wi); wr_data = pat(10'(10'h100 + wi)); #1;
         exp_r = ((c % 5) == 4);
         vecs++; if ({rd_ready, wr_ready} !== {exp_r, !exp_r})
            begin errs++; $display("FAIL arb_cycle%0d got rd=%b wr=%b want %b %b", c, rd_ready, wr_ready, exp_r, !exp_r); end
         if (resp_valid) begin
            vecs++; if (resp_data !== pat(10'(10'h020 + oi))) begin errs++; $display("FAIL arb_resp%0d got %h want %h", oi, resp_data, pat(10'(10'h020 + oi))); end
            oi++;
         end
         if (rd_ready) ri++;
         if (wr_ready) wi++;
         @(posedge clock); @(negedge clock);
      end
      wr_valid = 1'b0; rd_valid = 1'b0;
      repeat (3) begin
         #1;
         if (resp_valid) begin
            vecs++; if (resp_data !== pat(10'(10'h020 + oi))) begin errs++; $display("FAIL arb_drain%0d got %h want %h", oi, resp_data, pat(10'(10'h020 + oi))); end
            oi++;
         end
         @(posedge clock); @(negedge clock);
      end
      vecs++; if (ri !== 3 || oi !== 3) begin errs++; $display("FAIL arb_counts got reads=%0d resps=%0d want 3 3", ri, oi); end
      resp_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      int ri, oi;
      for (int i = 0; i < 5; i++) do_write(10'(10'h040 + i), 16'hFFFF, pat(10'(10'h040 + i)));
      ri = 0; oi = 0;
      resp_ready = 1'b0; rd_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         rd_addr = 10'(10'h040 + ri); #1;
         vecs++; if (rd_ready !== (c < 2)) begin errs++; $display("FAIL bp_accept%0d got %b want %b", c, rd_ready, (c < 2)); end
         if (rd_ready) ri++;
         @(posedge clock); @(negedge clock);
      end
      resp_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         rd_valid = (ri < 5); rd_addr = 10'(10'h040 + ri); #1;
         if (c == 0) begin
            vecs++; if (rd_ready !== 1'b1 || resp_data !== pat(10'h040))
               begin errs++; $display("FAIL bp_resume got rdy=%b head=%h want 1 %h", rd_ready, resp_data, pat(10'h040)); end
         end
         if (resp_valid) begin
            vecs++; if (resp_data !== pat(10'(10'h040 + oi))) begin errs++; $display("FAIL bp_resp%0d got %h want %h", oi, resp_data, pat(10'(10'h040 + oi))); end
            oi++;
         end
         if (rd_ready) ri++;
         @(posedge clock); @(negedge clock);
      end
      vecs++; if (ri !== 5 || oi !== 5) begin errs++; $display("FAIL bp_counts got reads=%0d resps=%0d want 5 5", ri, oi); end
      rd_valid = 1'b0; resp_ready = 1'b0;
   endtask

   task automatic test_reset_midflight();
      int n;
      logic stale, v;
      logic [527:0] d;
      resp_ready = 1'b0; rd_valid = 1'b1; rd_addr = 10'h040;
      @(posedge clock); @(negedge clock);
      rd_addr = 10'h041;
      @(posedge clock); @(negedge clock);
      #1;
      vecs++; if (rd_ready !== 1'b0) begin errs++; $display("FAIL mid_full got %b want 0", rd_ready); end
      rd_valid = 1'b0; reset_n = 1'b0;
      @(posedge clock); #1;
      vecs++; if (resp_valid !== 1'b0 || init_done !== 1'b0) begin errs++; $display("FAIL mid_reset_clear got v=%b done=%b want 0 0", resp_valid, init_done); end
      vecs++; if ({sram_en, sram_wmode, sram_addr} !== {2'b11, 10'h000}) begin errs++; $display("FAIL mid_init_restart got en=%b wm=%b addr=%h want 1 1 000", sram_en, sram_wmode, sram_addr); end
      @(negedge clock); reset_n = 1'b1;
      n = 0; stale = 1'b0;
      while (n < 2000) begin
         @(posedge clock); #1; n++;
         if (resp_valid) stale = 1'b1;
         if (init_done) break;
      end
      vecs++; if (stale !== 1'b0) begin errs++; $display("FAIL mid_stale got %b want 0", stale); end
      vecs++; if (n !== 1024) begin errs++; $display("FAIL mid_init_latency got %0d want 1024", n); end
      @(negedge clock);
      read_one(10'h040, v, d);
      vecs++; if (v !== 1'b1 || d !== '0) begin errs++; $display("FAIL mid_refill got v=%b d=%h want 1 0", v, d); end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired after %0d vectors", vecs);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_write_read();
      test_mask();
      test_arbitration();
      test_back_to_back();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
